mips_fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register.
//  - Owns the PC and issues word requests to instruction memory over a req/ack handshake.
//  - Presents {inst, pc, pc_plus4} to the decode stage with a valid bit.
//  - Applies redirects resolved in ID/EX (control_type_t), ERET, and exception entry.

---
 rtl/mips_fetch_stage_pkg.sv | 23 ++
 rtl/mips_next_pc.sv | 47 ++++
 rtl/mips_fetch_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: fetch FSM states, the
// ID-stage control classification and the nop encoding.
package mips_fetch_stage_pkg;

   // Control-flow class of the instruction currently in ID.
   typedef enum logic [1:0] {
      CT_SEQ      = 2'd0,
      CT_BRANCH   = 2'd1,
      CT_JUMP     = 2'd2,
      CT_JUMP_REG = 2'd3
   } control_type_t;

   // Fetch FSM: issuing, holding a word during a stall, or discarding a
   // request that a redirect has made stale.
   typedef enum logic [1:0] {
      S_ISSUE   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] OP_NOP = 32'h0;

endpackage

// File: rtl/mips_next_pc.sv
// Redirect target selection: picks the highest-priority redirect source
// among exception, ERET, jr, j and taken branch.
module mips_next_pc
   import mips_fetch_stage_pkg::*;
#(
   parameter int unsigned     PC_W       = 64,
   parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(64'h8000_0180)
) (
   input  logic            exc_valid,
   input  logic            eret_valid,
   input  logic [PC_W-1:0] epc,
   input  control_type_t   control_type,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] id_pc,
   input  logic [15:0]     br_imm,
   input  logic [25:0]     j_index,
   input  logic [PC_W-1:0] jr_target,
   output logic            redirect,
   output logic [PC_W-1:0] target
);

   logic [PC_W-1:0] id_pc_plus4;
   logic [PC_W-1:0] br_offset;

   assign id_pc_plus4 = id_pc + PC_W'(4);
   assign br_offset   = {{(PC_W-18){br_imm[15]}}, br_imm, 2'b00};

   // Priority chain, highest source first; arithmetic wraps modulo 2^PC_W.
   always_comb begin
      // NOTE: both outputs get a value before any branch so no latch is inferred.
      redirect = 1'b1;
      target   = '0;
      if (exc_valid)
         target = EXC_VECTOR;
      else if (eret_valid)
         target = epc;
      else if (control_type == CT_JUMP_REG)
         target = jr_target;
      else if (control_type == CT_JUMP)
         target = {id_pc_plus4[PC_W-1:28], j_index, 2'b00};
      else if ((control_type == CT_BRANCH) && branch_taken)
         target = id_pc_plus4 + br_offset;
      else
         redirect = 1'b0;
   end

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// applies redirects and drives the IF/ID pipeline register.
module mips_fetch_stage
   import mips_fetch_stage_pkg::*;
#(
   parameter int unsigned     PC_W       = 64,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(64'h8000_0180)
) (
   input  logic            clock,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic            flush,
   input  control_type_t   control_type,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] id_pc,
   input  logic [15:0]     br_imm,
   input  logic [25:0]     j_index,
   input  logic [PC_W-1:0] jr_target,
   input  logic            exc_valid,
   input  logic            eret_valid,
   input  logic [PC_W-1:0] epc,
   output logic            inst_valid,
   output logic [31:0]     inst,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus4
);

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   fetch_state_t    state, state_next;
   logic [PC_W-1:0] fetch_pc, fetch_pc_next, fetch_pc_inc;
   logic [PC_W-1:0] held_addr;
   logic [31:0]     buf_word;
   logic            started;
   logic            redirect;
   logic [PC_W-1:0] target;
   logic            load_ack, load_buf, capture_buf;

   assign fetch_pc_inc = fetch_pc + PC_STEP;

   mips_next_pc #(
      .PC_W       (PC_W),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_pc (
      .exc_valid    (exc_valid),
      .eret_valid   (eret_valid),
      .epc          (epc),
      .control_type (control_type),
      .branch_taken (branch_taken),
      .id_pc        (id_pc),
      .br_imm       (br_imm),
      .j_index      (j_index),
      .jr_target    (jr_target),
      .redirect     (redirect),
      .target       (target)
   );

   // Fetch FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
      if (!reset) state <= S_ISSUE;
      else        state <= state_next;
   end

   // Next state, next PC and which source (if any) loads IF/ID this cycle.
   always_comb begin
      state_next    = state;
      fetch_pc_next = redirect ? target : fetch_pc;
      load_ack      = 1'b0;
      load_buf      = 1'b0;
      capture_buf   = 1'b0;
      unique case (state)
         S_ISSUE: begin
            if (imem_req) begin
               if (redirect) begin
                  // An unanswered request must finish before the new PC is issued.
                  if (!imem_ack) state_next = S_DISCARD;
               end else if (imem_ack) begin
                  if (stall) begin
                     capture_buf = 1'b1;
                     state_next  = S_HOLD;
                  end else begin
                     load_ack      = 1'b1;
                     fetch_pc_next = fetch_pc_inc;
                  end
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               state_next = S_ISSUE;
            end else if (!stall) begin
               load_buf      = 1'b1;
               fetch_pc_next = fetch_pc_inc;
               state_next    = S_ISSUE;
            end
         end
         S_DISCARD: begin
            if (imem_ack) state_next = S_ISSUE;
         end
         default: state_next = S_ISSUE;
      endcase
   end

   // Bus outputs; the discard state keeps presenting the stale address.
   always_comb begin
      imem_req  = started && (state != S_HOLD);
      imem_addr = (state == S_DISCARD) ? held_addr : fetch_pc;
   end

   // PC, in-flight address, stall buffer and the post-reset start flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc  <= RESET_PC;
         held_addr <= RESET_PC;
         buf_word  <= OP_NOP;
         started   <= 1'b0;
      end else begin
         started  <= 1'b1;
         fetch_pc <= fetch_pc_next;
         if (state == S_ISSUE) held_addr <= fetch_pc;
         if (capture_buf)      buf_word  <= imem_rdata;
      end
   end

   // IF/ID register: squash on redirect/flush, load a word, hold on stall,
   // otherwise drain to a bubble.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         inst_valid <= 1'b0;
         inst       <= OP_NOP;
         pc         <= '0;
         pc_plus4   <= '0;
      end else if (redirect || flush) begin
         inst_valid <= 1'b0;
         inst       <= OP_NOP;
      end else if (load_ack || load_buf) begin
         inst_valid <= 1'b1;
         inst       <= load_ack ? imem_rdata : buf_word;
         pc         <= fetch_pc;
         pc_plus4   <= fetch_pc_inc;
      end else if (!stall) begin
         inst_valid <= 1'b0;
         inst       <= OP_NOP;
      end
   end

endmodule
